// File: rtl/add_round_key_pkg.sv
// Shared constants and types for the add_round_key stage.
//   - block/CPU data widths
//   - pointer-counter field layout
//   - debug register bit positions
//   - cpu_addr decode values
//   - FSM state type
package add_round_key_pkg;

  localparam int unsigned BLOCK_DATA_WIDTH = 128;
  localparam int unsigned CPU_DATA_WIDTH   = 32;

  localparam int unsigned PNTR_W       = 2;
  localparam int unsigned PNTR_FIELD_W = 8;
  localparam int unsigned NUM_PNTR     = 4;

  localparam int unsigned DBG_OVF       = 0;
  localparam int unsigned DBG_RD_COLL   = 1;
  localparam int unsigned DBG_KEY_FULL  = 2;
  localparam int unsigned DBG_DROP_LSB  = 8;
  localparam int unsigned DBG_DROP_MSB  = 15;

  localparam logic CPU_ADDR_CNTR = 1'b0;
  localparam logic CPU_ADDR_DBG  = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } ark_state_e;

endpackage

// File: rtl/add_round_key_if.sv
// Data, key and CPU signals of the add_round_key stage.
//   slave  : the add_round_key stage itself
//   master : the surrounding datapath / CPU (or a testbench)
interface add_round_key_if #(
  parameter int BLOCK_DATA_WIDTH = add_round_key_pkg::BLOCK_DATA_WIDTH,
  parameter int CPU_DATA_WIDTH   = add_round_key_pkg::CPU_DATA_WIDTH
);
  logic [BLOCK_DATA_WIDTH-1:0] data_in;
  logic                        data_in_vld;
  logic [1:0]                  pntr_num_in;
  logic [BLOCK_DATA_WIDTH-1:0] key_in;
  logic                        key_in_vld;
  logic                        key_in_rdy;
  logic [BLOCK_DATA_WIDTH-1:0] data_out;
  logic                        data_out_vld;
  logic [1:0]                  pntr_num_out;
  logic                        cpu_rd;
  logic                        cpu_addr;
  logic [CPU_DATA_WIDTH-1:0]   cpu_rd_data;

  modport slave (
    input  data_in, data_in_vld, pntr_num_in, key_in, key_in_vld, cpu_rd, cpu_addr,
    output key_in_rdy, data_out, data_out_vld, pntr_num_out, cpu_rd_data
  );

  modport master (
    output data_in, data_in_vld, pntr_num_in, key_in, key_in_vld, cpu_rd, cpu_addr,
    input  key_in_rdy, data_out, data_out_vld, pntr_num_out, cpu_rd_data
  );
endinterface

// File: rtl/add_round_key_key_fifo.sv
// key_fifo: synchronous register-array FIFO holding round keys.
//   push/din  : write din when push and not full
//   pop       : drop head when pop and not empty
//   full/empty: occupancy flags
//   head      : oldest entry (valid when !empty)
// Asynchronous active-high reset empties the FIFO.
module key_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/add_round_key.sv
// add_round_key: XORs each state block from mix_columns with the next round
// key from a small key FIFO and forwards it with its pointer number.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : add_round_key_if.slave
//     data_in/data_in_vld/pntr_num_in  : state block in (no backpressure)
//     key_in/key_in_vld/key_in_rdy     : round key in (valid/ready)
//     data_out/data_out_vld/pntr_num_out : result, 1-cycle latency
//     cpu_rd/cpu_addr/cpu_rd_data      : CPU read of pointer counters (0)
//                                        or debug register (1)
// A block arriving with no key available waits in a one-entry hold register;
// a further block arriving while still waiting is dropped and counted.
module add_round_key #(
  parameter int BLOCK_DATA_WIDTH = add_round_key_pkg::BLOCK_DATA_WIDTH,
  parameter int CPU_DATA_WIDTH   = add_round_key_pkg::CPU_DATA_WIDTH,
  parameter int KEY_FIFO_DEPTH   = 4
) (
  input logic            clk,
  input logic            reset,
  add_round_key_if.slave bus
);
  import add_round_key_pkg::*;

  logic                        fifo_full;
  logic                        fifo_empty;
  logic [BLOCK_DATA_WIDTH-1:0] fifo_head;
  logic                        push;
  logic                        pop;

  ark_state_e                  state;
  ark_state_e                  state_nxt;
  logic [BLOCK_DATA_WIDTH-1:0] hold_data;
  logic [1:0]                  hold_pntr;
  logic                        hold_load;

  logic                        emit;
  logic [BLOCK_DATA_WIDTH-1:0] emit_data;
  logic [1:0]                  emit_pntr;
  logic                        drop;

  logic [31:0]                 reg_pntr_cntr;
  logic [31:0]                 cntr_nxt;
  logic                        dbg_ovf;
  logic                        dbg_rd_coll;
  logic                        dbg_key_full;
  logic [7:0]                  dbg_drop_cnt;
  logic [CPU_DATA_WIDTH-1:0]   dbg_word;
  logic                        dbg_clr;

  assign bus.key_in_rdy = ~fifo_full & ~reset;
  assign push           = bus.key_in_vld & bus.key_in_rdy;
  assign pop            = emit;

  key_fifo #(
    .WIDTH (BLOCK_DATA_WIDTH),
    .DEPTH (KEY_FIFO_DEPTH)
  ) u_key_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (bus.key_in),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_data = bus.data_in;
    emit_pntr = bus.pntr_num_in;
    hold_load = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.data_in_vld) begin
          if (!fifo_empty) begin
            emit = 1'b1;
          end else begin
            hold_load = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (!fifo_empty) begin
          emit      = 1'b1;
          emit_data = hold_data;
          emit_pntr = hold_pntr;
          // A new block arriving as the held one leaves takes its place.
          if (bus.data_in_vld) hold_load = 1'b1;
          else                 state_nxt = IDLE;
        end else if (bus.data_in_vld) begin
          drop = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold_data <= '0;
      hold_pntr <= '0;
    end else begin
      state <= state_nxt;
      if (hold_load) begin
        hold_data <= bus.data_in;
        hold_pntr <= bus.pntr_num_in;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.data_out     <= '0;
      bus.data_out_vld <= 1'b0;
      bus.pntr_num_out <= '0;
    end else begin
      bus.data_out_vld <= emit;
      if (emit) begin
        bus.data_out     <= emit_data ^ fifo_head;
        bus.pntr_num_out <= emit_pntr;
      end
    end
  end

  always_comb begin
    cntr_nxt = reg_pntr_cntr;
    if (emit) begin
      cntr_nxt[int'(emit_pntr)*PNTR_FIELD_W +: PNTR_FIELD_W] =
        reg_pntr_cntr[int'(emit_pntr)*PNTR_FIELD_W +: PNTR_FIELD_W] + 8'd1;
    end
  end

  assign dbg_clr = bus.cpu_rd & (bus.cpu_addr == CPU_ADDR_DBG);

  always_comb begin
    dbg_word                             = '0;
    dbg_word[DBG_OVF]                    = dbg_ovf;
    dbg_word[DBG_RD_COLL]                = dbg_rd_coll;
    dbg_word[DBG_KEY_FULL]               = dbg_key_full;
    dbg_word[DBG_DROP_MSB:DBG_DROP_LSB]  = dbg_drop_cnt;
  end

  // Set events take priority over a clearing read in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_pntr_cntr   <= '0;
      dbg_ovf         <= 1'b0;
      dbg_rd_coll     <= 1'b0;
      dbg_key_full    <= 1'b0;
      dbg_drop_cnt    <= '0;
      bus.cpu_rd_data <= '0;
    end else begin
      reg_pntr_cntr <= cntr_nxt;
      dbg_ovf       <= drop | (dbg_ovf & ~dbg_clr);
      dbg_rd_coll   <= (bus.data_in_vld & bus.cpu_rd) | (dbg_rd_coll & ~dbg_clr);
      dbg_key_full  <= (bus.key_in_vld & fifo_full) | (dbg_key_full & ~dbg_clr);
      if (dbg_clr)
        dbg_drop_cnt <= drop ? 8'd1 : 8'd0;
      else if (drop && dbg_drop_cnt != 8'hFF)
        dbg_drop_cnt <= dbg_drop_cnt + 8'd1;
      if (!bus.cpu_rd)
        bus.cpu_rd_data <= '0;
      else if (bus.cpu_addr == CPU_ADDR_DBG)
        bus.cpu_rd_data <= dbg_word;
      else
        bus.cpu_rd_data <= CPU_DATA_WIDTH'(reg_pntr_cntr);
    end
  end
endmodule
